// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: order codes, 2-bit counter encodings and decode helper shared by the BHT.
// Contents: instruction order codes (same values as the branch classifier),
//           counter states SNT/WNT/WT/ST, is_cond() for BEQ..BGEU.
package branch_predictor_pkg;
    localparam logic [5:0] JALR = 6'd12;
    localparam logic [5:0] JAL  = 6'd30;
    localparam logic [5:0] BEQ  = 6'd31;
    localparam logic [5:0] BNE  = 6'd32;
    localparam logic [5:0] BLT  = 6'd33;
    localparam logic [5:0] BGE  = 6'd34;
    localparam logic [5:0] BLTU = 6'd35;
    localparam logic [5:0] BGEU = 6'd36;
    localparam logic [1:0] SNT  = 2'b00;
    localparam logic [1:0] WNT  = 2'b01;
    localparam logic [1:0] WT   = 2'b10;
    localparam logic [1:0] ST   = 2'b11;
    function automatic logic is_cond(input logic [5:0] order);
        return order >= BEQ && order <= BGEU;
    endfunction
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// branch_predictor_sat_counter2: combinational next state of a 2-bit saturating counter.
// Ports: i_cnt current counter, i_taken resolved outcome, o_cnt next counter.
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);
    always_comb
        o_cnt = i_taken ? ((i_cnt == ST) ? ST : i_cnt + 2'd1)
                        : ((i_cnt == SNT) ? SNT : i_cnt - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BHT of 2-bit saturating counters giving a registered next-PC prediction.
// Ports: clk_in/rst_in (async, active-high)/rdy_in (low freezes state);
//        q_* query from decode, p_* prediction one cycle later,
//        u_* commit-time training from the ROB, flush squashes the in-flight query.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         BHT_ADDR_W = 8,
    parameter logic [1:0] CNT_INIT   = WNT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        q_valid,
    input  logic [31:0] q_pc,
    input  logic [5:0]  q_order,
    input  logic        q_is_br,
    input  logic [31:0] q_imm,
    output logic        p_valid,
    output logic        p_taken,
    output logic [31:0] p_pc,
    input  logic        u_valid,
    input  logic [31:0] u_pc,
    input  logic        u_taken,
    input  logic        u_is_cond,
    input  logic        flush
);
    logic [1:0]            r_bht [2**BHT_ADDR_W];
    logic                  r_p_valid;
    logic                  r_p_taken;
    logic [31:0]           r_p_pc;
    logic [BHT_ADDR_W-1:0] w_q_idx;
    logic [BHT_ADDR_W-1:0] w_u_idx;
    logic [1:0]            w_u_next;
    logic                  w_accept;
    logic                  w_taken;
    logic [31:0]           w_pc;

    assign w_q_idx  = q_pc[BHT_ADDR_W+1:2];
    assign w_u_idx  = u_pc[BHT_ADDR_W+1:2];
    assign w_accept = q_valid && !flush;

    // JALR falls through to pc+4: its target is unknown here and the ROB recovers it.
    always_comb begin
        w_taken = q_is_br && (q_order == JAL || (is_cond(q_order) && r_bht[w_q_idx][1]));
        w_pc    = q_pc + (w_taken ? q_imm : 32'd4);
    end

    branch_predictor_sat_counter2 u_sat (
        .i_cnt   (r_bht[w_u_idx]),
        .i_taken (u_taken),
        .o_cnt   (w_u_next)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_p_valid <= 1'b0;
            r_p_taken <= 1'b0;
            r_p_pc    <= 32'd0;
        end else if (rdy_in) begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p_taken <= w_taken;
                r_p_pc    <= w_pc;
            end
        end
    end

    // Commit updates are non-speculative, so flush does not block them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_bht <= '{default: CNT_INIT};
        else if (rdy_in && u_valid && u_is_cond)
            r_bht[w_u_idx] <= w_u_next;
    end

    assign p_valid = r_p_valid;
    assign p_taken = r_p_taken;
    assign p_pc    = r_p_pc;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch history table (BHT) of 2-bit saturating counters, sitting beside instruction fetch/decode.
- Consumes the branch-class flag and 6-bit order code from the Branch classifier for each decoded instruction and returns a registered next-PC prediction to fetch.
- Trained by the ROB at commit with the resolved outcome of conditional branches.
- Flushed on misprediction recovery.

Parameters:
- BHT_ADDR_W, 8, log2 of table entries; index = pc[BHT_ADDR_W+1:2].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  asynchronous reset, active-high
- rdy_in  input  1  global ready; low = freeze all state
- q_valid  input  1  query present this cycle
- q_pc  input  32  PC of queried instruction
- q_order  input  6  decoded order code (JALR=12, JAL=30, BEQ..BGEU=31..36)
- q_is_br  input  1  Branch classifier output for q_order
- q_imm  input  32  sign-extended B/J immediate
- p_valid  output  1  prediction valid (1-cycle pulse per query)
- p_taken  output  1  predicted taken
- p_pc  output  32  predicted next PC
- u_valid  input  1  commit update present
- u_pc  input  32  PC of committed branch
- u_taken  input  1  resolved outcome
- u_is_cond  input  1  committed instr is conditional (BEQ..BGEU)
- flush  input  1  squash in-flight prediction

Behaviour:
- Reset (async, rst_in=1): p_valid=0, p_taken=0, p_pc=0, all counters=CNT_INIT. Reset mid-query drops the query and emits no prediction.
- rdy_in=0: no register or counter changes; outputs hold their last values.
- Query latency: 1 cycle. A query accepted at edge N (q_valid=1, rdy_in=1, flush=0) produces p_valid=1 after edge N+1 for exactly one cycle. A new query every cycle is allowed (fully pipelined, no backpressure).
- Prediction rules (evaluated from the counter value sampled at edge N):
  - q_is_br=0: p_taken=0, p_pc=q_pc+4.
  - order JAL: p_taken=1, p_pc=q_pc+q_imm.
  - order JALR: p_taken=0, p_pc=q_pc+4. The target is unknown; the ROB recovers.
  - Conditional: p_taken=cnt[1]; p_pc = taken ? q_pc+q_imm : q_pc+4.
- Address arithmetic is 32-bit modulo with wrap-around and no overflow flag.
- Update: on an edge with u_valid & u_is_cond & rdy_in, the counter at index(u_pc) is incremented if u_taken and decremented otherwise, saturating at 2'b11 and 2'b00. Updates with u_is_cond=0 are ignored.
- Simultaneous query and update to the same index: the prediction uses the pre-update counter value; the update still takes effect.
- Aliasing: PCs sharing index bits share a counter. No tag check.
- flush=1 at an edge: p_valid=0 next cycle and any query in that cycle is discarded. Updates in the same cycle are still applied, because commit is non-speculative.
- q_valid=0: p_valid=0 next cycle; p_taken/p_pc hold their last values.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/defines holds the order codes JALR, JAL, BEQ, BNE, BLT, BGE, BLTU, BGEU (same values as the classifier), plus the 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11.
- Optional sub-module: sat_counter2 (combinational next-state: in cnt, taken → out cnt). The table array and prediction register stay in branch_predictor.

Test Plan:
1. Reset, then query BEQ at q_pc=0x100, q_imm=0x20 → next cycle p_valid=1, p_taken=0, p_pc=0x104.
2. Two updates u_pc=0x100 taken (cnt 01→10→11), then same query → p_taken=1, p_pc=0x120. Then one not-taken update (11→10) → still taken. A second not-taken update (→01) → p_taken=0.
3. Query JAL q_pc=0x200, q_imm=0xFFFFFFF0 → p_taken=1, p_pc=0x1F0. Query JALR at 0x200 → p_taken=0, p_pc=0x204. Non-branch (q_is_br=0) → p_pc=0x204.
4. Same-cycle query and taken update at 0x100 with counter 01 → prediction not-taken; the following query → taken (counter 10).
5. Aliasing, BHT_ADDR_W=8: two taken updates at 0x500 → query BNE at 0x100 predicts taken.
6. Query with flush=1 → p_valid=0 next cycle. rdy_in=0 during query and update → no p_valid pulse and counter unchanged. rst_in asserted mid-stream → outputs 0 immediately and counters back to 01.
